// File: rtl/iscas_bist_pkg.sv
// Shared types and default constants for the ISCAS'89 BIST controller.
package iscas_bist_pkg;

    localparam int unsigned SIG_W = 32;
    localparam int unsigned CNT_W = 16;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

    // Pattern / flush counter
    typedef logic [CNT_W-1:0] cnt_t;

    localparam logic [SIG_W-1:0] DEF_LFSR_SEED = 32'h0000_0001;
    localparam logic [SIG_W-1:0] DEF_LFSR_POLY = 32'h8020_0003;
    localparam logic [SIG_W-1:0] DEF_MISR_POLY = 32'h04C1_1DB7;

endpackage : iscas_bist_pkg

// File: rtl/bist_misr.sv
// 32-bit multiple-input signature register compacting the CUT outputs.
module bist_misr
    import iscas_bist_pkg::*;
#(
    parameter int unsigned      PO_W      = 19,
    parameter logic [SIG_W-1:0] MISR_POLY = DEF_MISR_POLY
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [PO_W-1:0]  i_po,
    output logic [SIG_W-1:0] o_sig,
    output logic [SIG_W-1:0] o_sig_next_c
);

    logic [SIG_W-1:0] r_sig;

    // Next signature: clear wins over absorb; otherwise hold
    always_comb begin
        o_sig_next_c = r_sig;
        if (i_clr) begin
            o_sig_next_c = '0;
        end else if (i_en) begin
            o_sig_next_c = (r_sig << 1)
                         ^ (r_sig[SIG_W-1] ? MISR_POLY : '0)
                         ^ SIG_W'(i_po);
        end
    end

    // Signature register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sig <= '0;
        end else begin
            r_sig <= o_sig_next_c;
        end
    end

    assign o_sig = r_sig;

endmodule : bist_misr

// File: rtl/iscas_bist_ctrl.sv
// BIST controller: clears the CUT, drives LFSR patterns, compacts responses.
module iscas_bist_ctrl
    import iscas_bist_pkg::*;
#(
    parameter int unsigned      PI_W       = 18,
    parameter int unsigned      PO_W       = 19,
    parameter int unsigned      N_PATTERNS = 1024,
    parameter int unsigned      FLUSH_CYC  = 4,
    parameter int unsigned      CLR_BIT    = 17,
    parameter logic             CLR_VAL    = 1'b1,
    parameter logic [SIG_W-1:0] LFSR_SEED  = DEF_LFSR_SEED,
    parameter logic [SIG_W-1:0] LFSR_POLY  = DEF_LFSR_POLY,
    parameter logic [SIG_W-1:0] MISR_POLY  = DEF_MISR_POLY,
    parameter logic [SIG_W-1:0] GOLDEN     = 32'h0
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             START,
    input  logic [PO_W-1:0]  PO,
    output logic [PI_W-1:0]  PI,
    output logic             BUSY,
    output logic             DONE,
    output logic [SIG_W-1:0] SIG,
    output logic             PASS
);

    localparam cnt_t FLUSH_LAST = CNT_W'(FLUSH_CYC - 1);
    localparam cnt_t RUN_LAST   = CNT_W'(N_PATTERNS - 1);

    // An all-zero seed would lock the LFSR at zero
    if (LFSR_SEED == '0) begin : g_bad_seed
        $error("iscas_bist_ctrl: LFSR_SEED must be non-zero");
    end

    bist_state_e      r_state, w_state_next;
    logic [SIG_W-1:0] r_lfsr, w_lfsr_next, w_lfsr_step;
    cnt_t             r_cnt, w_cnt_next;
    logic [PI_W-1:0]  r_pi, w_pi_next;
    logic             r_busy, r_done, r_pass;
    logic             w_misr_clr, w_misr_en, w_done_entry;
    logic [SIG_W-1:0] w_sig, w_sig_next;

    assign w_lfsr_step  = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_POLY : '0);
    assign w_done_entry = (r_state == ST_RUN) && (w_state_next == ST_DONE);

    // Next-state, LFSR/counter update and MISR control
    always_comb begin
        w_state_next = r_state;
        w_lfsr_next  = r_lfsr;
        w_cnt_next   = r_cnt;
        w_misr_clr   = 1'b0;
        w_misr_en    = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    w_state_next = ST_FLUSH;
                    w_lfsr_next  = LFSR_SEED;
                    w_cnt_next   = '0;
                    w_misr_clr   = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (r_cnt == FLUSH_LAST) begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + cnt_t'(1);
                end
            end
            ST_RUN: begin
                w_misr_en   = 1'b1;
                w_lfsr_next = w_lfsr_step;
                w_cnt_next  = r_cnt + cnt_t'(1);
                if (r_cnt == RUN_LAST) begin
                    w_state_next = ST_DONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // CUT input for the cycle about to start, clear pin forced per phase
    always_comb begin
        w_pi_next = '0;
        if (w_state_next == ST_FLUSH) begin
            w_pi_next          = w_lfsr_next[PI_W-1:0];
            w_pi_next[CLR_BIT] = CLR_VAL;
        end else if (w_state_next == ST_RUN) begin
            w_pi_next          = w_lfsr_next[PI_W-1:0];
            w_pi_next[CLR_BIT] = ~CLR_VAL;
        end
    end

    // State register
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath and output registers
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_lfsr <= LFSR_SEED;
            r_cnt  <= '0;
            r_pi   <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else begin
            r_lfsr <= w_lfsr_next;
            r_cnt  <= w_cnt_next;
            r_pi   <= w_pi_next;
            r_busy <= (w_state_next == ST_FLUSH) || (w_state_next == ST_RUN);
            r_done <= (w_state_next == ST_DONE);
            if (w_done_entry) begin
                r_pass <= (w_sig_next == GOLDEN);
            end else if (w_misr_clr) begin
                r_pass <= 1'b0;
            end
        end
    end

    bist_misr #(
        .PO_W      (PO_W),
        .MISR_POLY (MISR_POLY)
    ) u_misr (
        .i_clk        (CK),
        .i_rst_n      (RN),
        .i_clr        (w_misr_clr),
        .i_en         (w_misr_en),
        .i_po         (PO),
        .o_sig        (w_sig),
        .o_sig_next_c (w_sig_next)
    );

    assign PI   = r_pi;
    assign BUSY = r_busy;
    assign DONE = r_done;
    assign SIG  = w_sig;
    assign PASS = r_pass;

endmodule : iscas_bist_ctrl

// File: tb/tb_iscas_bist_ctrl.sv
// Directed self-checking bench for iscas_bist_ctrl.
module tb_iscas_bist_ctrl;

    logic        ck;
    logic        rn;

    // Instance A: default sizing, PO tied low
    logic        start_a;
    logic [18:0] po_a;
    logic [17:0] pi_a;
    logic        busy_a, done_a, pass_a;
    logic [31:0] sig_a;

    // Instance B: two patterns, PO = 1, golden mismatch
    logic        start_b;
    logic [18:0] po_b;
    logic [17:0] pi_b;
    logic        busy_b, done_b, pass_b;
    logic [31:0] sig_b;

    // Instance C: 32-bit PO to exercise MISR feedback, golden match
    logic        start_c;
    logic [31:0] po_c;
    logic [17:0] pi_c;
    logic        busy_c, done_c, pass_c;
    logic [31:0] sig_c;

    int checks;
    int errors;
    int n;

    iscas_bist_ctrl dut_a (
        .CK(ck), .RN(rn), .START(start_a), .PO(po_a), .PI(pi_a),
        .BUSY(busy_a), .DONE(done_a), .SIG(sig_a), .PASS(pass_a)
    );

    iscas_bist_ctrl #(
        .N_PATTERNS(2), .GOLDEN(32'h0)
    ) dut_b (
        .CK(ck), .RN(rn), .START(start_b), .PO(po_b), .PI(pi_b),
        .BUSY(busy_b), .DONE(done_b), .SIG(sig_b), .PASS(pass_b)
    );

    iscas_bist_ctrl #(
        .PO_W(32), .N_PATTERNS(2), .GOLDEN(32'h04C1_1DB7)
    ) dut_c (
        .CK(ck), .RN(rn), .START(start_c), .PO(po_c), .PI(pi_c),
        .BUSY(busy_c), .DONE(done_c), .SIG(sig_c), .PASS(pass_c)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rn      = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        po_a    = '0;
        po_b    = 19'h1;
        po_c    = '0;

        // Reset values
        @(negedge ck);
        chk("rst_pi",   32'(pi_a), 32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        chk("rst_done", 32'(done_a), 32'h0);
        chk("rst_pass", 32'(pass_a), 32'h0);
        chk("rst_sig",  sig_a, 32'h0);
        rn = 1'b1;
        @(negedge ck);

        // Instance A: full default run, stimulus and handshake
        start_a = 1'b1;
        @(negedge ck);
        start_a = 1'b0;
        n = 0;
        while (busy_a === 1'b1 && n < 3000) begin
            if (n < 4)   chk("a_flush_pi", 32'(pi_a), 32'h2_0001);
            if (n == 4)  chk("a_pat0_pi",  32'(pi_a), 32'h0_0001);
            if (n == 5)  chk("a_pat1_pi",  32'(pi_a), 32'h0_0003);
            if (n == 6)  chk("a_pat2_pi",  32'(pi_a), 32'h0_0002);
            if (n == 100) start_a = 1'b1;
            if (n == 101) start_a = 1'b0;
            n++;
            @(negedge ck);
        end
        chk("a_busy_len", 32'(n), 32'd1028);
        chk("a_done",     32'(done_a), 32'h1);
        chk("a_sig",      sig_a, 32'h0);
        chk("a_pass",     32'(pass_a), 32'h1);
        chk("a_pi_done",  32'(pi_a), 32'h0);
        @(negedge ck);
        chk("a_done_hold", 32'(done_a), 32'h1);

        // Instance C: MSB feedback of the MISR, golden match
        start_c = 1'b1;
        @(negedge ck);
        start_c = 1'b0;
        n = 0;
        while (busy_c === 1'b1 && n < 100) begin
            po_c = (n == 4) ? 32'h8000_0000 : 32'h0;
            n++;
            @(negedge ck);
        end
        chk("c_busy_len", 32'(n), 32'd6);
        chk("c_done",     32'(done_c), 32'h1);
        chk("c_sig",      sig_c, 32'h04C1_1DB7);
        chk("c_pass",     32'(pass_c), 32'h1);

        // Instance B: MISR arithmetic and golden mismatch
        start_b = 1'b1;
        @(negedge ck);
        start_b = 1'b0;
        n = 0;
        while (busy_b === 1'b1 && n < 100) begin
            n++;
            @(negedge ck);
        end
        chk("b_busy_len", 32'(n), 32'd6);
        chk("b_done",     32'(done_b), 32'h1);
        chk("b_sig",      sig_b, 32'h3);
        chk("b_pass",     32'(pass_b), 32'h0);

        // START held in DONE restarts on the next edge
        start_b = 1'b1;
        @(negedge ck);
        chk("b_restart_done", 32'(done_b), 32'h0);
        chk("b_restart_busy", 32'(busy_b), 32'h1);
        chk("b_restart_sig",  sig_b, 32'h0);
        chk("b_restart_pi",   32'(pi_b), 32'h2_0001);
        start_b = 1'b0;
        repeat (5) @(negedge ck);
        chk("b_mid_pi",  32'(pi_b), 32'h0_0003);
        chk("b_mid_sig", sig_b, 32'h1);

        // Asynchronous reset mid-RUN
        #2 rn = 1'b0;
        #1;
        chk("rr_pi",   32'(pi_b), 32'h0);
        chk("rr_sig",  sig_b, 32'h0);
        chk("rr_busy", 32'(busy_b), 32'h0);
        chk("rr_done", 32'(done_b), 32'h0);
        chk("rr_pass", 32'(pass_b), 32'h0);
        @(negedge ck);
        rn = 1'b1;
        repeat (8) @(negedge ck);
        chk("rr_no_done", 32'(done_b), 32'h0);
        chk("rr_idle",    32'(busy_b), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_iscas_bist_ctrl
